// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM controller arbiter.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 21;
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned LAT_W       = 4;
    localparam int unsigned DEF_RD_LAT  = 6;
    localparam int unsigned DEF_WR_LAT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Latched command of the granted requester
    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; last_q remembers the most recent grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       any_c,
    output logic       gnt_c
);

    logic last_q;

    // On a tie the port that was not granted last wins
    always_comb begin
        any_c = |req_i;
        gnt_c = 1'b0;
        if (req_i == 2'b10) begin
            gnt_c = 1'b1;
        end else if (req_i == 2'b11) begin
            gnt_c = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant_en_i && any_c) begin
            last_q <= gnt_c;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between fetch (port 0) and data (port 1)
// with round-robin arbitration and fixed per-command latency.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned WR_LAT = DEF_WR_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [SRAM_ADDR_W-1:0] p0_addr,
    input  logic [SRAM_DATA_W-1:0] p0_wdata,
    output logic                   p0_ack,
    output logic [SRAM_DATA_W-1:0] p0_rdata,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [SRAM_ADDR_W-1:0] p1_addr,
    input  logic [SRAM_DATA_W-1:0] p1_wdata,
    output logic                   p1_ack,
    output logic [SRAM_DATA_W-1:0] p1_rdata,
    output logic                   mem_wr_en,
    output logic                   mem_rd_en,
    output logic [SRAM_ADDR_W-1:0] mem_addr,
    output logic [SRAM_DATA_W-1:0] mem_wr_data,
    input  logic [SRAM_DATA_W-1:0] mem_rd_data,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [LAT_W-1:0]       cnt_q, cnt_d;
    sram_cmd_t              cmd_q, cmd_d;
    logic                   win_q, win_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [SRAM_DATA_W-1:0] rdata0_q, rdata0_d;
    logic [SRAM_DATA_W-1:0] rdata1_q, rdata1_d;
    logic                   busy_q, busy_d;
    logic                   grant_en;
    logic                   any_c;
    logic                   gnt_c;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .req_i      ({p1_req, p0_req}),
        .grant_en_i (grant_en),
        .any_c      (any_c),
        .gnt_c      (gnt_c)
    );

    // Enables and acks are computed one cycle ahead so they land registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        win_d    = win_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_c) begin
                    grant_en = 1'b1;
                    win_d    = gnt_c;
                    cmd_d    = gnt_c ? '{we: p1_we, addr: p1_addr, wdata: p1_wdata}
                                     : '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
                    rd_en_d  = ~cmd_d.we;
                    wr_en_d  = cmd_d.we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = cmd_q.we ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);
                rd_en_d = ~cmd_q.we;
                wr_en_d = cmd_q.we;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = DONE;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    if (!cmd_q.we) begin
                        if (win_q) rdata1_d = mem_rd_data;
                        else       rdata0_d = mem_rd_data;
                    end
                end else begin
                    rd_en_d = ~cmd_q.we;
                    wr_en_d = cmd_q.we;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            win_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            win_q    <= win_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign p0_ack      = ack0_q;
    assign p1_ack      = ack1_q;
    assign p0_rdata    = rdata0_q;
    assign p1_rdata    = rdata1_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = cmd_q.addr;
    assign mem_wr_data = cmd_q.wdata;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an ack scoreboard and SRAM read model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [20:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [20:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        busy;

    typedef struct {
        logic        port;
        logic        we;
        logic [20:0] addr;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   d;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM read model: data only driven while the read enable is high
    function automatic logic [31:0] mem_fn(input logic [20:0] a);
        return 32'hDEADBEEF ^ {11'd0, a ^ 21'h00010};
    endfunction

    always_comb mem_rd_data = mem_rd_en ? mem_fn(mem_addr) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic we, input logic [20:0] addr, input int ack_cyc);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic we, input logic [20:0] addr, input logic [31:0] wd);
        if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    endtask

    // Score acks; drop a port's req once it has no further pending transactions
    task automatic check_acks();
        exp_t e;
        logic more;
        if (p0_ack || p1_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'({p1_ack, p0_ack}), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 64'({p1_ack, p0_ack}), e.port ? 64'd2 : 64'd1);
                chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
                if (!e.we) chk("ack_rdata", 64'(e.port ? p1_rdata : p0_rdata), 64'(mem_fn(e.addr)));
                more = 1'b0;
                foreach (sb[i]) if (sb[i].port == e.port) more = 1'b1;
                if (!more) begin
                    if (e.port) p1_req = 1'b0;
                    else        p0_req = 1'b0;
                end
            end
        end else if (sb.size() != 0 && cyc >= sb[0].ack_cyc) begin
            e = sb.pop_front();
            chk("ack_missing", 64'({p1_ack, p0_ack}), e.port ? 64'd2 : 64'd1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_acks();
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0 && !busy) break;
            step();
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 64'({p1_ack, p0_ack}), 64'd0);
        chk({tag, "_rdata0"}, 64'(p0_rdata), 64'd0);
        chk({tag, "_rdata1"}, 64'(p1_rdata), 64'd0);
        chk({tag, "_en"}, 64'({mem_wr_en, mem_rd_en}), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wr_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;

        // Continuous tie from reset: 0,1,0,1 spaced 9 cycles
        d = cyc;
        drive(1'b0, 1'b0, 21'h00200, 32'h0);
        drive(1'b1, 1'b0, 21'h00300, 32'h0);
        push(1'b0, 1'b0, 21'h00200, d + 8);
        push(1'b1, 1'b0, 21'h00300, d + 17);
        push(1'b0, 1'b0, 21'h00200, d + 26);
        push(1'b1, 1'b0, 21'h00300, d + 35);
        drain(60);

        // Single read on port 0
        d = cyc;
        drive(1'b0, 1'b0, 21'h00010, 32'h0);
        push(1'b0, 1'b0, 21'h00010, d + 8);
        drain(20);
        repeat (2) step();
        chk("p0_rdata_hold", 64'(p0_rdata), 64'h00000000DEADBEEF);
        chk("p1_rdata_hold", 64'(p1_rdata), 64'(mem_fn(21'h00300)));

        // Single write on port 1: enable window and stable address/data
        d = cyc;
        drive(1'b1, 1'b1, 21'h00100, 32'h12345678);
        push(1'b1, 1'b1, 21'h00100, d + 6);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("wr_en", 64'(mem_wr_en), (k <= 5) ? 64'd1 : 64'd0);
            chk("wr_rd_en", 64'(mem_rd_en), 64'd0);
            chk("wr_addr", 64'(mem_addr), 64'h100);
            chk("wr_wdata", 64'(mem_wr_data), 64'h12345678);
        end
        drain(10);

        // Port 1 inputs change mid-transaction
        d = cyc;
        drive(1'b1, 1'b1, 21'h00AA0, 32'hCAFEF00D);
        push(1'b1, 1'b1, 21'h00AA0, d + 6);
        repeat (3) step();
        p1_addr = 21'h1FFFFF;
        p1_wdata = 32'hFFFFFFFF;
        for (int k = 4; k <= 6; k++) begin
            step();
            chk("latch_addr", 64'(mem_addr), 64'hAA0);
            chk("latch_wdata", 64'(mem_wr_data), 64'hCAFEF00D);
        end
        drain(10);

        // Port 0 drops req during WAIT; transaction still completes
        d = cyc;
        drive(1'b0, 1'b0, 21'h00044, 32'h0);
        push(1'b0, 1'b0, 21'h00044, d + 8);
        repeat (3) step();
        p0_req = 1'b0;
        drain(20);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_rd_en", 64'(mem_rd_en), 64'd0);
        end

        // Reset at the WAIT midpoint aborts with no ack
        drive(1'b0, 1'b0, 21'h00088, 32'h0);
        repeat (4) step();
        chk("pre_rst_rd_en", 64'(mem_rd_en), 64'd1);
        rst = 1'b1;
        p0_req = 1'b0;
        step();
        chk_zero("mid_rst");
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("post_rst_ack", 64'({p1_ack, p0_ack}), 64'd0);
        end

        // Tie after reset grants port 0 first
        d = cyc;
        drive(1'b0, 1'b0, 21'h00010, 32'h0);
        drive(1'b1, 1'b0, 21'h00020, 32'h0);
        push(1'b0, 1'b0, 21'h00010, d + 8);
        push(1'b1, 1'b0, 21'h00020, d + 17);
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter sharing the single 32-bit SRAM controller between the instruction-fetch port (port 0) and the data/loader port (port 1). It latches one request at a time, drives the controller's enable/address/data lines for a fixed per-command latency, then returns read data and a one-cycle acknowledge to the winning port. It uses round-robin arbitration so that neither fetch nor load/store traffic can starve the other.

## Interface
- RD_LAT, 6: cycles the controller needs from read enable to valid `mem_rd_data`; legal range 1..15.
- WR_LAT, 4: cycles the controller needs to complete a write; legal range 1..15.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- p0_req, p1_req  in  1  request; held high until matching ack.
- p0_we, p1_we  in  1  1 = write, 0 = read; valid with req.
- p0_addr, p1_addr  in  21  byte address (halfword-aligned).
- p0_wdata, p1_wdata  in  32  write data.
- p0_ack, p1_ack  out  1  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  32  read data, valid on ack and held until next read ack on that port.
- mem_wr_en, mem_rd_en  out  1  controller command enables.
- mem_addr  out  21  controller address.
- mem_wr_data  out  32  controller write data.
- mem_rd_data  in  32  controller read data.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, select a winner, latch its we/addr/wdata and the winner index, then go to ISSUE. If no req is high, stay in IDLE.
- Arbitration: if only one port requests, it wins. If both request, the port not granted last wins. The `last` pointer updates on every grant and resets to 1, so port 0 wins the first tie.
- ISSUE: assert mem_rd_en (read) or mem_wr_en (write). Load the counter with RD_LAT or WR_LAT, then go to WAIT.
- WAIT: keep the enable asserted and decrement the counter each cycle. When counter == 1, go to DONE.
- DONE: deassert both enables. Pulse the winner's ack. For a read, capture mem_rd_data into the winner's rdata register. Return to IDLE.
- mem_addr and mem_wr_data come from the latch registers and are stable from ISSUE through DONE. Requester inputs changing mid-transaction have no effect.
- If req drops before ack, the transaction still completes and ack still pulses. Requesters must ignore an unexpected ack.
- A port may re-request in the cycle after its ack. Arbitration then considers it normally.
- Enables are low for at least 2 cycles (DONE and IDLE) between commands, which guarantees a clean rising edge for the controller's edge detection.

## Timing
- Reset values: state IDLE; last = 1; counter 0. All outputs 0: acks, rdata, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, busy.
- Reset asserted mid-transaction aborts it: no ack is issued and the enables drop on the next edge.
- Request sampled in IDLE at cycle 0. ISSUE is cycle 1; all mem_* outputs are registered, so enables are high from cycle 1.
- Read: ack at cycle 1 + RD_LAT + 1, which is cycle 8 for RD_LAT = 6. rdata is valid in the same cycle.
- Write: ack at cycle 1 + WR_LAT + 1, which is cycle 6 for WR_LAT = 4.
- Peak throughput: one transaction per RD_LAT + 3 (or WR_LAT + 3) cycles.
- Simultaneous new req and ack on the same port: the ack belongs to the old transaction. The new req is sampled in the following IDLE cycle.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - SRAM_ADDR_W = 21, SRAM_DATA_W = 32;
  - default latencies.
- Sub-module `rr_arb2`: a combinational two-request round-robin picker with a registered `last` pointer, reusable elsewhere.
- The FSM, latency counter and latch registers stay in `sram_arbiter`.

## Test plan
- Single read, port 0, addr 0x00010, mem_rd_data = 0xDEADBEEF -> p0_ack at cycle 8, p0_rdata = 0xDEADBEEF, p1_ack never high.
- Single write, port 1, addr 0x00100, wdata 0x12345678 -> mem_wr_en high cycles 1–5, mem_addr = 0x00100, mem_wr_data = 0x12345678 throughout, p1_ack at cycle 6.
- Both ports request reads continuously from reset -> grant order 0,1,0,1. Each ack is spaced RD_LAT + 3 = 9 cycles apart.
- Port 1 changes addr and wdata during WAIT -> mem_addr and mem_wr_data stay at the latched values, and the ack is still issued.
- Port 0 drops req in WAIT -> the transaction completes and p0_ack pulses. The next IDLE with no requests stays idle and busy = 0.
- rst asserted at the WAIT midpoint -> the next cycle has all outputs 0 and state IDLE, with no ack. After release, a tie grants port 0.
